// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
// Read-side consumer for the asynchronous FIFO, running in the read clock
// domain. It pops bytes from the FIFO read port and packs them into
// BYTES_PER_WORD-wide little-endian words. Each word leaves on a valid/ready
// stream with a per-byte keep mask. A partial word is sent when the idle
// timeout expires or when a flush is requested.
//
// Ports
//   rd_clk   : read-domain clock, all logic on the rising edge
//   rst      : synchronous active-high reset
//   rd_empty : FIFO empty flag
//   data_in  : FIFO data_out, valid the cycle after an accepted rdreq
//   rdreq    : FIFO pop request
//   flush    : single-cycle request to emit the current partial word
//   m_data   : packed word, first byte in bits [7:0]
//   m_keep   : byte-valid mask, lane i = bit i
//   m_valid  : output word valid
//   m_ready  : downstream accept
module fifo_rd_packer #(
   parameter int BYTES_PER_WORD = 4,
   parameter int TIMEOUT        = 16
) (
   input  logic                        rd_clk,
   input  logic                        rst,
   input  logic                        rd_empty,
   input  logic [7:0]                  data_in,
   output logic                        rdreq,
   input  logic                        flush,
   output logic [8*BYTES_PER_WORD-1:0] m_data,
   output logic [BYTES_PER_WORD-1:0]   m_keep,
   output logic                        m_valid,
   input  logic                        m_ready
);

   localparam int CW = $clog2(BYTES_PER_WORD + 1);
   localparam int IW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] FULL      = CW'(BYTES_PER_WORD);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

   typedef enum logic {FILL, HOLD} state_e;

   state_e                      state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic                        pend_q;
   logic [IW-1:0]               idle_q, idle_d;
   logic                        flushLat_q, flushLat_d;
   logic [8*BYTES_PER_WORD-1:0] asm_q, asm_d;
   logic [8*BYTES_PER_WORD-1:0] outData_q, outData_d;
   logic [BYTES_PER_WORD-1:0]   outKeep_q, outKeep_d;
   logic                        outValid_q, outValid_d;

   logic [CW-1:0]               cntLand;
   logic [8*BYTES_PER_WORD-1:0] asmLand;
   logic [BYTES_PER_WORD-1:0]   keepLand;
   logic                        idleInc;
   logic                        timeoutFire;
   logic                        flushReq;
   logic                        flushNow;
   logic                        wordDone;
   logic                        outFree;
   logic                        loadOut;

   // The pop request looks only at rd_empty, rst and registered state.
   // Counting the in-flight byte keeps the assembly register from overflowing.
   assign rdreq = !rst && !rd_empty && (state_q == FILL) && !flushLat_q &&
                  ((cnt_q + CW'(pend_q)) < FULL);

   // The in-flight byte lands this cycle. The word view below already
   // includes it, so a transfer in the same cycle carries that byte too.
   always_comb begin
      asmLand  = asm_q;
      keepLand = '0;
      cntLand  = cnt_q + CW'(pend_q);
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         if (pend_q && (cnt_q == CW'(i))) begin
            asmLand[8*i +: 8] = data_in;
         end
         keepLand[i] = (CW'(i) < cntLand);
      end
   end

   // The idle counter only runs while a partial word waits with no read
   // in flight and none about to be issued.
   assign idleInc     = (state_q == FILL) && (cnt_q != '0) && !pend_q && !rdreq;
   assign timeoutFire = idleInc && (idle_q == IDLE_LAST);

   // A flush with nothing collected is dropped. If a pop goes out in the
   // same cycle, the flush is held until that byte lands, so the byte joins
   // the flushed word. While the flush is held, no more pops are issued.
   assign flushReq   = (state_q == FILL) && (flush || flushLat_q) &&
                       ((cnt_q != '0) || pend_q);
   assign flushNow   = flushReq && !rdreq;
   assign flushLat_d = flushReq && rdreq;

   assign wordDone = (state_q == FILL) && ((cntLand == FULL) || timeoutFire || flushNow);
   assign outFree  = !outValid_q || m_ready;
   assign loadOut  = (wordDone || (state_q == HOLD)) && outFree;

   // Next-state logic. A finished word goes straight into the output register
   // when that register is free or being drained this cycle. Otherwise the
   // word is parked in HOLD until the output frees.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cntLand;
      asm_d      = asmLand;
      idle_d     = idle_q;
      outData_d  = outData_q;
      outKeep_d  = outKeep_q;
      outValid_d = outValid_q && !m_ready;

      if (pend_q) begin
         idle_d = '0;
      end else if (idleInc) begin
         idle_d = idle_q + IW'(1);
      end

      if (loadOut) begin
         outData_d  = asmLand;
         outKeep_d  = keepLand;
         outValid_d = 1'b1;
         cnt_d      = '0;
         asm_d      = '0;
         idle_d     = '0;
         state_d    = FILL;
      end else if (wordDone) begin
         idle_d  = '0;
         state_d = HOLD;
      end
   end

   // State registers. Reset drops any partial word, any output word and any
   // byte still in flight.
   always_ff @(posedge rd_clk) begin
      if (rst) begin
         state_q    <= FILL;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         idle_q     <= '0;
         flushLat_q <= 1'b0;
         asm_q      <= '0;
         outData_q  <= '0;
         outKeep_q  <= '0;
         outValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_q     <= rdreq;
         idle_q     <= idle_d;
         flushLat_q <= flushLat_d;
         asm_q      <= asm_d;
         outData_q  <= outData_d;
         outKeep_q  <= outKeep_d;
         outValid_q <= outValid_d;
      end
   end

   assign m_data  = outData_q;
   assign m_keep  = outKeep_q;
   assign m_valid = outValid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer
// Self-checking bench for fifo_rd_packer. A queue stands in for the FIFO.
// The reference model is the byte stream itself: every accepted word must
// carry the oldest popped bytes in order, in low contiguous lanes, with zero
// padding. Directed steps then pin down the exact word values and latencies.
module tb_fifo_rd_packer;

   localparam int B  = 4;
   localparam int TO = 16;

   logic           rd_clk = 1'b0;
   logic           rst;
   logic           rd_empty;
   logic [7:0]     data_in;
   logic           rdreq;
   logic           flush;
   logic [8*B-1:0] m_data;
   logic [B-1:0]   m_keep;
   logic           m_valid;
   logic           m_ready;

   int total = 0;
   int bad   = 0;
   int cycleNum = 0;
   int pops = 0;
   int inSystem = 0;

   byte unsigned   fifoQ[$];
   byte unsigned   flightQ[$];
   logic [8*B-1:0] wordQ[$];
   logic [B-1:0]   keepQ[$];
   int             acceptCyc[$];
   int             popCycQ[$];

   bit             rstDrv = 1'b1;
   bit             flushDrv = 1'b0;
   bit             readyDrv = 1'b0;
   bit             emptyForce = 1'b0;
   bit             popLast = 1'b0;
   byte unsigned   popByte = 8'h00;
   bit             prevHeld = 1'b0;
   bit             prevRst = 1'b1;
   logic [8*B-1:0] prevData;
   logic [B-1:0]   prevKeep;

   fifo_rd_packer #(
      .BYTES_PER_WORD(B),
      .TIMEOUT(TO)
   ) dut (
      .rd_clk(rd_clk),
      .rst(rst),
      .rd_empty(rd_empty),
      .data_in(data_in),
      .rdreq(rdreq),
      .flush(flush),
      .m_data(m_data),
      .m_keep(m_keep),
      .m_valid(m_valid),
      .m_ready(m_ready)
   );

   // Free-running read clock.
   always #5 rd_clk = ~rd_clk;

   // One comparison: count it, and report tag/observed/expected on a miss.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle. Inputs are driven just after the falling edge. Outputs
   // are sampled 1 ns later. The FIFO queue, the stream model and the
   // protocol checks are all updated here.
   task automatic applyStimulus();
      int nKeep;
      @(negedge rd_clk);
      cycleNum++;
      data_in  = popLast ? popByte : 8'($urandom);
      rst      = rstDrv;
      flush    = flushDrv;
      m_ready  = readyDrv;
      rd_empty = (fifoQ.size() == 0) || emptyForce;
      #1;
      if (prevHeld && !prevRst) begin
         checkOutput("hold_valid", 64'(m_valid), 64'd1);
         checkOutput("hold_data", 64'(m_data), 64'(prevData));
         checkOutput("hold_keep", 64'(m_keep), 64'(prevKeep));
      end
      prevHeld = m_valid && !m_ready;
      prevRst  = rst;
      prevData = m_data;
      prevKeep = m_keep;

      if (m_valid && m_ready) begin
         nKeep = 0;
         checkOutput("keep_shape",
                     64'((m_keep != '0) && (((m_keep + 1'b1) & m_keep) == '0)), 64'd1);
         for (int i = 0; i < B; i++) begin
            if (m_keep[i]) begin
               nKeep++;
               checkOutput("stream_byte", 64'(m_data[8*i +: 8]),
                           (flightQ.size() > 0) ? 64'(flightQ.pop_front()) : 64'h100);
            end else begin
               checkOutput("pad_zero", 64'(m_data[8*i +: 8]), 64'd0);
            end
         end
         wordQ.push_back(m_data);
         keepQ.push_back(m_keep);
         acceptCyc.push_back(cycleNum);
         inSystem -= nKeep;
      end

      popLast = 1'b0;
      if (rdreq) begin
         checkOutput("rdreq_while_empty", 64'(rd_empty), 64'd0);
         checkOutput("pop_bound", 64'(inSystem < 2*B), 64'd1);
         popByte = (fifoQ.size() > 0) ? fifoQ.pop_front() : 8'h00;
         flightQ.push_back(popByte);
         popCycQ.push_back(cycleNum);
         popLast = 1'b1;
         pops++;
         inSystem++;
      end

      if (rst) begin
         flightQ.delete();
         inSystem = 0;
      end
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   // Bounded wait until n words have been accepted.
   task automatic waitWords(input int n, input int bound, input string tag);
      int k;
      k = 0;
      while ((wordQ.size() < n) && (k < bound)) begin
         applyStimulus();
         k++;
      end
      checkOutput(tag, 64'(wordQ.size() >= n), 64'd1);
   endtask

   // Bounded wait until n pops have been recorded since the last clear.
   task automatic waitPops(input int n, input int bound, input string tag);
      int k;
      k = 0;
      while ((popCycQ.size() < n) && (k < bound)) begin
         applyStimulus();
         k++;
      end
      checkOutput(tag, 64'(popCycQ.size() >= n), 64'd1);
   endtask

   task automatic takeWord(output logic [8*B-1:0] d, output logic [B-1:0] k, output int c);
      if (wordQ.size() > 0) begin
         d = wordQ.pop_front();
         k = keepQ.pop_front();
         c = acceptCyc.pop_front();
      end else begin
         d = 'x;
         k = 'x;
         c = -1;
      end
   endtask

   task automatic clearLogs();
      wordQ.delete();
      keepQ.delete();
      acceptCyc.delete();
      popCycQ.delete();
   endtask

   initial begin
      logic [8*B-1:0] d;
      logic [B-1:0]   k;
      int             c;
      int             c0;
      int             last;
      int             p0;

      rst      = 1'b1;
      rd_empty = 1'b1;
      flush    = 1'b0;
      m_ready  = 1'b0;
      data_in  = 8'h00;

      // Reset state.
      rstDrv = 1'b1;
      runCycles(2);
      checkOutput("reset_valid", 64'(m_valid), 64'd0);
      checkOutput("reset_keep", 64'(m_keep), 64'd0);
      checkOutput("reset_data", 64'(m_data), 64'd0);
      checkOutput("reset_rdreq", 64'(rdreq), 64'd0);
      rstDrv = 1'b0;

      // Full words at full rate.
      clearLogs();
      readyDrv = 1'b1;
      for (int i = 0; i < 8; i++) fifoQ.push_back(8'(i));
      p0 = pops;
      waitWords(2, 60, "t1_words_arrive");
      runCycles(5);
      checkOutput("t1_pops", 64'(pops - p0), 64'd8);
      takeWord(d, k, c0);
      checkOutput("t1_word0", 64'(d), 64'h03020100);
      checkOutput("t1_keep0", 64'(k), 64'hF);
      checkOutput("t1_latency", 64'(c0), (popCycQ.size() >= 4) ? 64'(popCycQ[3] + 2) : 64'hFFFF);
      takeWord(d, k, c);
      checkOutput("t1_word1", 64'(d), 64'h07060504);
      checkOutput("t1_keep1", 64'(k), 64'hF);
      checkOutput("t1_rate", 64'(c - c0), 64'(B + 1));

      // Backpressure: two words buffered, then pops stop.
      clearLogs();
      readyDrv = 1'b0;
      for (int i = 0; i < 12; i++) fifoQ.push_back(8'(8'h10 + i));
      p0 = pops;
      runCycles(30);
      checkOutput("t2_pops", 64'(pops - p0), 64'd8);
      checkOutput("t2_rdreq_low", 64'(rdreq), 64'd0);
      checkOutput("t2_valid", 64'(m_valid), 64'd1);
      checkOutput("t2_held_word", 64'(m_data), 64'h13121110);
      readyDrv = 1'b1;
      waitWords(3, 60, "t2_words_arrive");
      takeWord(d, k, c);
      checkOutput("t2_word0", 64'(d), 64'h13121110);
      takeWord(d, k, c);
      checkOutput("t2_word1", 64'(d), 64'h17161514);
      takeWord(d, k, c);
      checkOutput("t2_word2", 64'(d), 64'h1B1A1918);
      checkOutput("t2_keep2", 64'(k), 64'hF);
      runCycles(30);
      checkOutput("t2_no_extra", 64'(wordQ.size()), 64'd0);

      // Timeout emits a partial word TIMEOUT+1 cycles after the last landing.
      clearLogs();
      fifoQ.push_back(8'hA1);
      fifoQ.push_back(8'hA2);
      fifoQ.push_back(8'hA3);
      waitPops(3, 20, "t3_pops");
      last = popCycQ[2];
      waitWords(1, 40, "t3_word_arrives");
      takeWord(d, k, c);
      checkOutput("t3_timeout_cycle", 64'(c), 64'(last + 1 + TO + 1));
      checkOutput("t3_word", 64'(d), 64'h00A3A2A1);
      checkOutput("t3_keep", 64'(k), 64'h7);

      // A fourth byte arriving at idle=10 restarts the timer and completes the word.
      clearLogs();
      fifoQ.push_back(8'hB1);
      fifoQ.push_back(8'hB2);
      fifoQ.push_back(8'hB3);
      waitPops(3, 20, "t3b_pops");
      last = popCycQ[2];
      while (cycleNum < last + 11) applyStimulus();
      fifoQ.push_back(8'hC4);
      waitWords(1, 40, "t3b_word_arrives");
      takeWord(d, k, c);
      checkOutput("t3b_word", 64'(d), 64'hC4B3B2B1);
      checkOutput("t3b_keep", 64'(k), 64'hF);
      checkOutput("t3b_cycle", 64'(c), 64'(last + 14));

      // Flush while the second byte is in flight.
      clearLogs();
      fifoQ.push_back(8'h55);
      waitPops(1, 20, "t4_pop0");
      runCycles(3);
      fifoQ.push_back(8'h66);
      waitPops(2, 20, "t4_pop1");
      flushDrv = 1'b1;
      applyStimulus();
      flushDrv = 1'b0;
      waitWords(1, 20, "t4_word_arrives");
      takeWord(d, k, c);
      checkOutput("t4_word", 64'(d), 64'h00006655);
      checkOutput("t4_keep", 64'(k), 64'h3);
      runCycles(30);
      checkOutput("t4_no_extra", 64'(wordQ.size()), 64'd0);

      // A flush with nothing collected produces no word.
      flushDrv = 1'b1;
      applyStimulus();
      flushDrv = 1'b0;
      runCycles(25);
      checkOutput("t4_flush_empty", 64'(wordQ.size()), 64'd0);

      // Reset mid-operation: held word, partial word and in-flight byte are all dropped.
      clearLogs();
      readyDrv = 1'b0;
      for (int i = 0; i < 6; i++) fifoQ.push_back(8'(8'h40 + i));
      runCycles(15);
      checkOutput("t5_held_word", 64'(m_data), 64'h43424140);
      fifoQ.push_back(8'h46);
      applyStimulus();
      checkOutput("t5_inflight_pop", 64'(rdreq), 64'd1);
      rstDrv = 1'b1;
      applyStimulus();
      rstDrv = 1'b0;
      applyStimulus();
      checkOutput("t5_valid_cleared", 64'(m_valid), 64'd0);
      checkOutput("t5_keep_cleared", 64'(m_keep), 64'd0);
      checkOutput("t5_rdreq_low", 64'(rdreq), 64'd0);
      clearLogs();
      readyDrv = 1'b1;
      for (int i = 0; i < 4; i++) fifoQ.push_back(8'(8'h50 + i));
      waitWords(1, 30, "t5_word_arrives");
      takeWord(d, k, c);
      checkOutput("t5_fresh_word", 64'(d), 64'h53525150);
      checkOutput("t5_fresh_keep", 64'(k), 64'hF);

      // Random empty/ready/flush traffic against the byte-stream model.
      clearLogs();
      for (int n = 0; n < 2000; n++) begin
         emptyForce = ($urandom_range(0, 3) == 0);
         readyDrv   = ($urandom_range(0, 2) != 0);
         flushDrv   = ($urandom_range(0, 39) == 0);
         while (fifoQ.size() < 3) fifoQ.push_back(8'($urandom));
         applyStimulus();
      end
      emptyForce = 1'b0;
      flushDrv   = 1'b0;
      readyDrv   = 1'b1;
      runCycles(80);
      checkOutput("t6_traffic", 64'(wordQ.size() > 100), 64'd1);
      checkOutput("t6_fifo_drained", 64'(fifoQ.size()), 64'd0);
      checkOutput("t6_stream_drained", 64'(flightQ.size()), 64'd0);
      checkOutput("t6_in_system", 64'(inSystem), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
